nios2_debug_jtag_host: RTL and testbench

- Host-side JTAG initiator that drives a TAP chain containing the Nios II virtual-JTAG debug slave.
- Turns system-clock scan commands (IR or DR, length, data) into TCK/TMS/TDI sequences and returns the captured TDO bits.
- Used for on-chip self-test and simulation of the debug-slave path without an external cable.
- Sits between a command source (bench or controller FSM) and the tck/tms/tdi/tdo pins of the debug chain.

---
 rtl/nios2_debug_jtag_host.sv | 183 ++++++++++++++++++
 tb/tb_nios2_debug_jtag_host.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_debug_jtag_host.sv
// Host-side JTAG initiator: turns IR/DR scan commands into TCK/TMS/TDI step
// sequences for the Nios II debug TAP chain and returns the captured TDO bits.
module nios2_debug_jtag_host #(
  parameter int CLK_DIV  = 2,
  parameter int DR_WIDTH = 38
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_is_ir,
  input  logic [5:0]          cmd_len,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                busy,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);

  localparam int TW = $clog2(2 * CLK_DIV + 1);
  localparam int CW = $clog2(DR_WIDTH + 7);
  localparam logic [TW-1:0] T_RISE    = TW'(CLK_DIV);
  localparam logic [TW-1:0] T_LAST    = TW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] WALK_LAST = CW'(5);

  typedef enum logic [2:0] {
    TRST_WALK,
    IDLE,
    SEL_DR,
    SEL_IR,
    CAPTURE,
    SHIFT,
    EXIT1,
    UPDATE
  } state_t;

  state_t              state_reg, state_next;
  logic [TW-1:0]       timer_reg, timer_next;
  logic [CW-1:0]       step_reg, step_next;
  logic [CW-1:0]       bit_reg, bit_next;
  logic [CW-1:0]       len_reg, len_eff;
  logic                is_ir_reg;
  logic [DR_WIDTH-1:0] data_reg;
  logic [DR_WIDTH-1:0] cap_reg;
  logic [DR_WIDTH-1:0] rsp_data_reg;
  logic                rsp_valid_reg;
  logic                accept, step_done, sample, bit_last, scan_done;

  // Lengths beyond the data path are clamped so a scan never runs off the end.
  always_comb begin
    if ({1'b0, cmd_len} > 7'(DR_WIDTH)) len_eff = CW'(DR_WIDTH);
    else                                len_eff = CW'(cmd_len);
  end

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign step_done = busy && (timer_reg == T_LAST);
  assign sample    = (state_reg == SHIFT) && (timer_reg == T_RISE);
  assign bit_last  = (bit_reg == len_reg - CW'(1));
  assign tck       = busy && (timer_reg >= T_RISE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    step_next  = step_reg;
    bit_next   = bit_reg;
    scan_done  = 1'b0;
    tms        = 1'b0;
    tdi        = 1'b0;
    if (state_reg != IDLE)
      timer_next = step_done ? '0 : timer_reg + TW'(1);
    case (state_reg)
      TRST_WALK: begin
        tms = (step_reg != WALK_LAST);
        if (step_done) begin
          step_next = step_reg + CW'(1);
          if (step_reg == WALK_LAST) begin
            state_next = IDLE;
            step_next  = '0;
          end
        end
      end
      IDLE: begin
        if (accept) begin
          bit_next   = '0;
          step_next  = '0;
          timer_next = '0;
          // Zero-length commands complete without touching the TAP.
          if (len_eff != '0) state_next = SEL_DR;
        end
      end
      SEL_DR: begin
        tms = 1'b1;
        if (step_done) state_next = is_ir_reg ? SEL_IR : CAPTURE;
      end
      SEL_IR: begin
        tms = 1'b1;
        if (step_done) state_next = CAPTURE;
      end
      CAPTURE: begin
        // Two TMS=0 steps: into Capture, then into Shift.
        if (step_done) begin
          step_next = step_reg + CW'(1);
          if (step_reg == CW'(1)) begin
            state_next = SHIFT;
            step_next  = '0;
          end
        end
      end
      SHIFT: begin
        tms = bit_last;
        tdi = data_reg[0];
        if (step_done) begin
          if (bit_last) state_next = EXIT1;
          else          bit_next   = bit_reg + CW'(1);
        end
      end
      EXIT1: begin
        tms = 1'b1;
        if (step_done) state_next = UPDATE;
      end
      UPDATE: begin
        if (step_done) begin
          state_next = IDLE;
          scan_done  = 1'b1;
        end
      end
      default: state_next = TRST_WALK;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= TRST_WALK;
      timer_reg     <= '0;
      step_reg      <= '0;
      bit_reg       <= '0;
      len_reg       <= '0;
      is_ir_reg     <= 1'b0;
      data_reg      <= '0;
      rsp_data_reg  <= '0;
      rsp_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      step_reg      <= step_next;
      bit_reg       <= bit_next;
      rsp_valid_reg <= scan_done || (accept && (len_eff == '0));
      if (accept) begin
        len_reg   <= len_eff;
        is_ir_reg <= cmd_is_ir;
        data_reg  <= cmd_data;
      end else if ((state_reg == SHIFT) && step_done) begin
        data_reg <= data_reg >> 1;
      end
      if (scan_done)
        rsp_data_reg <= cap_reg;
      else if (accept && (len_eff == '0))
        rsp_data_reg <= '0;
    end
  end

  // Each capture bit loads TDO only on its own shift step; unused bits stay 0.
  generate
    for (genvar gi = 0; gi < DR_WIDTH; gi++) begin : g_cap
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          cap_reg[gi] <= 1'b0;
        else if (accept)
          cap_reg[gi] <= 1'b0;
        else if (sample && (bit_reg == CW'(gi)))
          cap_reg[gi] <= tdo;
      end
    end
  endgenerate

endmodule

// File: tb/tb_nios2_debug_jtag_host.sv
// Bench for nios2_debug_jtag_host: two hosts (CLK_DIV=2 and 1), each driving a
// behavioural TAP with a 38-bit DR and 2-bit IR, checked against a shift model.
module tb_nios2_debug_jtag_host;
  localparam int DW  = 38;
  localparam int IRW = 2;

  typedef enum int {
    TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
    SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR
  } tap_t;

  typedef struct {
    bit             is_ir;
    bit [5:0]       len;
    logic [DW-1:0]  data;
    logic [DW-1:0]  exp_rsp;
    int             exp_steps;
    logic [127:0]   exp_tms;
    logic [DW-1:0]  exp_reg;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] cmd_valid_v, cmd_is_ir_v, cmd_ready_v, rsp_valid_v, busy_v;
  logic [1:0] tck_v, tms_v, tdi_v, tdo_v, preload_stb;
  logic [1:0][5:0]    cmd_len_v;
  logic [1:0][DW-1:0] cmd_data_v, rsp_data_v, preload_val;
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0]  shadow_dr;
  logic [IRW-1:0] shadow_ir;
  vec_t vecs[$];

  always #5 clk = ~clk;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:  return m ? TLR  : RTI;
      RTI:  return m ? SDR  : RTI;
      SDR:  return m ? SIR  : CDR;
      CDR:  return m ? E1DR : SHDR;
      SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR  : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR  : SHDR;
      UDR:  return m ? SDR  : RTI;
      SIR:  return m ? TLR  : CIR;
      CIR:  return m ? E1IR : SHIR;
      SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR  : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR  : SHIR;
      default: return m ? SDR : RTI;
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      nios2_debug_jtag_host #(.CLK_DIV(gi == 0 ? 2 : 1), .DR_WIDTH(DW)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_valid(cmd_valid_v[gi]),
        .cmd_ready(cmd_ready_v[gi]),
        .cmd_is_ir(cmd_is_ir_v[gi]),
        .cmd_len  (cmd_len_v[gi]),
        .cmd_data (cmd_data_v[gi]),
        .rsp_valid(rsp_valid_v[gi]),
        .rsp_data (rsp_data_v[gi]),
        .busy     (busy_v[gi]),
        .tck      (tck_v[gi]),
        .tms      (tms_v[gi]),
        .tdi      (tdi_v[gi]),
        .tdo      (tdo_v[gi])
      );

      tap_t           tap_st = TLR;
      logic [DW-1:0]  tap_dr = '0;
      logic [IRW-1:0] tap_ir = '0;
      int             pulses = 0;
      bit             tms_log[$];
      logic           tdo_r = 1'b0;

      always @(posedge tck_v[gi] or posedge preload_stb[gi]) begin
        if (preload_stb[gi]) begin
          tap_dr <= preload_val[gi];
        end else begin
          if (tap_st == SHDR) tap_dr <= {tdi_v[gi], tap_dr[DW-1:1]};
          if (tap_st == SHIR) tap_ir <= {tdi_v[gi], tap_ir[IRW-1:1]};
          tap_st <= tap_next(tap_st, tms_v[gi]);
          pulses <= pulses + 1;
          tms_log.push_back(tms_v[gi]);
        end
      end

      always @(negedge tck_v[gi])
        tdo_r <= (tap_st == SHDR) ? tap_dr[0] : (tap_st == SHIR) ? tap_ir[0] : 1'b0;

      assign tdo_v[gi] = tdo_r;
    end
  endgenerate

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scan model: the chosen register and the incoming bits form one long shift
  // stream; the first n bits out are the response, the next W bits the new reg.
  task automatic model_scan(input bit is_ir, input bit [5:0] len, input logic [DW-1:0] data,
                            output vec_t v);
    int n, w, k;
    logic [127:0] m, d, comb;
    n = (int'(len) > DW) ? DW : int'(len);
    w = is_ir ? IRW : DW;
    m = (128'd1 << n) - 128'd1;
    d = 128'(data) & m;
    comb = (d << w) | (is_ir ? 128'(shadow_ir) : 128'(shadow_dr));
    v.is_ir   = is_ir;
    v.len     = len;
    v.data    = data;
    v.exp_rsp = DW'(comb & m);
    if (is_ir) begin
      shadow_ir = IRW'(comb >> n);
      v.exp_reg = DW'(shadow_ir);
    end else begin
      shadow_dr = DW'(comb >> n);
      v.exp_reg = shadow_dr;
    end
    v.exp_tms   = '0;
    v.exp_steps = 0;
    if (n > 0) begin
      k = 0;
      v.exp_tms[k] = 1'b1; k = k + 1;
      if (is_ir) begin v.exp_tms[k] = 1'b1; k = k + 1; end
      k = k + 2;
      for (int i = 0; i < n; i++) begin
        v.exp_tms[k] = (i == n - 1);
        k = k + 1;
      end
      v.exp_tms[k] = 1'b1;
      k = k + 2;
      v.exp_steps = k;
    end
    $display("vector is_ir=%0d len=%0d data=%0h exp_rsp=%0h steps=%0d",
             is_ir, len, data, v.exp_rsp, v.exp_steps);
  endtask

  function automatic logic [127:0] tms_slice0(input int start);
    logic [127:0] r;
    r = '0;
    for (int i = 0; (start + i < g_inst[0].tms_log.size()) && (i < 128); i++)
      r[i] = g_inst[0].tms_log[start + i];
    return r;
  endfunction

  // Called at a negedge; host 0 (CLK_DIV=2) spends 4 clk cycles per step.
  task automatic run_vec(input vec_t v, input string tag);
    int start_p, start_l, lat;
    logic [DW-1:0] got;
    start_p = g_inst[0].pulses;
    start_l = g_inst[0].tms_log.size();
    cmd_valid_v[0] = 1'b1;
    cmd_is_ir_v[0] = v.is_ir;
    cmd_len_v[0]   = v.len;
    cmd_data_v[0]  = v.data;
    lat = -1;
    for (int c = 1; c <= 500; c++) begin
      @(negedge clk);
      cmd_valid_v[0] = 1'b0;
      if (rsp_valid_v[0]) begin
        lat = c;
        break;
      end
    end
    got = rsp_data_v[0];
    $display("scan %s is_ir=%0d len=%0d rsp=%0h latency=%0d", tag, v.is_ir, v.len, got, lat);
    check({tag, "_latency"}, 128'(lat), 128'(v.exp_steps * 4 + 1));
    check({tag, "_rsp"}, 128'(got), 128'(v.exp_rsp));
    check({tag, "_tck_pulses"}, 128'(g_inst[0].pulses - start_p), 128'(v.exp_steps));
    check({tag, "_tms_seq"}, tms_slice0(start_l), v.exp_tms);
    check({tag, "_tap_reg"}, v.is_ir ? 128'(g_inst[0].tap_ir) : 128'(g_inst[0].tap_dr),
          128'(v.exp_reg));
    check({tag, "_tap_state"}, 128'(g_inst[0].tap_st), 128'(RTI));
    @(negedge clk);
    check({tag, "_rsp_pulse"}, 128'(rsp_valid_v[0]), 128'(0));
    check({tag, "_rsp_hold"}, 128'(rsp_data_v[0]), 128'(v.exp_rsp));
  endtask

  initial begin
    vec_t v;
    logic [DW-1:0] p1, d1, d2, rsp1, rsp2, keep;
    int cyc, lat1, lat2, start_p, start_l;
    bit seen, rdy;

    reset_n     = 1'b0;
    cmd_valid_v = '0;
    cmd_is_ir_v = '0;
    cmd_len_v   = '0;
    cmd_data_v  = '0;
    preload_stb = '0;
    preload_val[0] = 38'h15_5555_5555;
    p1 = DW'({$urandom(), $urandom()});
    preload_val[1] = p1;
    #1 preload_stb = 2'b11;
    #1 preload_stb = 2'b00;
    shadow_dr = preload_val[0];
    shadow_ir = '0;

    model_scan(1'b0, 6'd38, 38'h2A_AAAA_AAAA, v); vecs.push_back(v);
    model_scan(1'b1, 6'd2, 38'h2, v);             vecs.push_back(v);
    model_scan(1'b0, 6'd0, DW'({$urandom(), $urandom()}), v);  vecs.push_back(v);
    model_scan(1'b0, 6'd50, DW'({$urandom(), $urandom()}), v); vecs.push_back(v);
    model_scan(1'b0, 6'd1, DW'({$urandom(), $urandom()}), v);  vecs.push_back(v);
    for (int i = 0; i < 10; i++) begin
      bit ir;
      ir = ($urandom_range(0, 3) == 0);
      model_scan(ir, ir ? 6'($urandom_range(0, 6)) : 6'($urandom_range(0, 63)),
                 DW'({$urandom(), $urandom()}), v);
      vecs.push_back(v);
    end

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 128'(cmd_ready_v[0]), 128'(0));
    check("rst_rsp_valid", 128'(rsp_valid_v[0]), 128'(0));
    check("rst_rsp_data", 128'(rsp_data_v[0]), 128'(0));
    check("rst_busy", 128'(busy_v[0]), 128'(1));
    check("rst_tck", 128'(tck_v[0]), 128'(0));
    check("rst_tms", 128'(tms_v[0]), 128'(1));
    check("rst_tdi", 128'(tdi_v[0]), 128'(0));

    // TRST walk after release
    reset_n = 1'b1;
    cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (cmd_ready_v[0]) begin
        cyc = c;
        break;
      end
    end
    $display("walk ready after %0d cycles, pulses=%0d", cyc, g_inst[0].pulses);
    check("walk_ready_cycle", 128'(cyc), 128'(24));
    check("walk_busy_low", 128'(busy_v[0]), 128'(0));
    check("walk_pulses", 128'(g_inst[0].pulses), 128'(6));
    check("walk_tms", tms_slice0(0), 128'(6'b011111));
    check("walk_tap_state", 128'(g_inst[0].tap_st), 128'(RTI));
    check("walk1_pulses", 128'(g_inst[1].pulses), 128'(6));

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // Abort during shift bit 10 (the 14th TCK rise of a DR scan)
    start_p = g_inst[0].pulses;
    cmd_valid_v[0] = 1'b1;
    cmd_is_ir_v[0] = 1'b0;
    cmd_len_v[0]   = 6'd38;
    cmd_data_v[0]  = DW'({$urandom(), $urandom()});
    seen = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      cmd_valid_v[0] = 1'b0;
      if (g_inst[0].pulses - start_p >= 14) break;
    end
    check("abort_tck_high", 128'(tck_v[0]), 128'(1));
    reset_n = 1'b0;
    #1;
    $display("abort: tck=%0d tms=%0d cmd_ready=%0d busy=%0d", tck_v[0], tms_v[0],
             cmd_ready_v[0], busy_v[0]);
    check("abort_tck", 128'(tck_v[0]), 128'(0));
    check("abort_tms", 128'(tms_v[0]), 128'(1));
    check("abort_cmd_ready", 128'(cmd_ready_v[0]), 128'(0));
    check("abort_busy", 128'(busy_v[0]), 128'(1));
    start_p = g_inst[0].pulses;
    start_l = g_inst[0].tms_log.size();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen = seen | rsp_valid_v[0];
    end
    reset_n = 1'b1;
    cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      seen = seen | rsp_valid_v[0];
      if (cmd_ready_v[0]) begin
        cyc = c;
        break;
      end
    end
    check("abort_no_rsp", 128'(seen), 128'(0));
    check("rewalk_ready_cycle", 128'(cyc), 128'(24));
    check("rewalk_pulses", 128'(g_inst[0].pulses - start_p), 128'(6));
    check("rewalk_tms", tms_slice0(start_l), 128'(6'b011111));
    check("rewalk_tap_state", 128'(g_inst[0].tap_st), 128'(RTI));

    // Resync DR contents after the partial scan and confirm normal operation
    keep = DW'({$urandom(), $urandom()});
    preload_val[0] = keep;
    preload_stb = 2'b01;
    #1 preload_stb = 2'b00;
    shadow_dr = keep;
    @(negedge clk);
    model_scan(1'b0, 6'd20, DW'({$urandom(), $urandom()}), v);
    run_vec(v, "post_abort");

    // Back-to-back on the CLK_DIV=1 host
    cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      if (cmd_ready_v[1]) begin
        cyc = c;
        break;
      end
      @(negedge clk);
    end
    check("b2b_host_ready", 128'(cyc > 0), 128'(1));
    start_p = g_inst[1].pulses;
    d1 = DW'({$urandom(), $urandom()});
    d2 = DW'({$urandom(), $urandom()});
    cmd_valid_v[1] = 1'b1;
    cmd_is_ir_v[1] = 1'b0;
    cmd_len_v[1]   = 6'd4;
    cmd_data_v[1]  = d1;
    lat1 = -1;
    rdy  = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) cmd_data_v[1] = d2;
      if (rsp_valid_v[1]) begin
        lat1 = c;
        rsp1 = rsp_data_v[1];
        rdy  = cmd_ready_v[1];
        break;
      end
    end
    $display("b2b first: rsp=%0h latency=%0d ready=%0d", rsp1, lat1, rdy);
    check("b2b_lat1", 128'(lat1), 128'(19));
    check("b2b_rsp1", 128'(rsp1), 128'(p1 & 38'hF));
    check("b2b_ready_in_rsp", 128'(rdy), 128'(1));
    lat2 = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_valid_v[1] = 1'b0;
        check("b2b_busy_next", 128'(busy_v[1]), 128'(1));
      end
      if (rsp_valid_v[1]) begin
        lat2 = c;
        rsp2 = rsp_data_v[1];
        break;
      end
    end
    $display("b2b second: rsp=%0h latency=%0d", rsp2, lat2);
    check("b2b_lat2", 128'(lat2), 128'(19));
    check("b2b_rsp2", 128'(rsp2), 128'((p1 >> 4) & 38'hF));
    check("b2b_pulses", 128'(g_inst[1].pulses - start_p), 128'(18));
    check("b2b_tap_dr", 128'(g_inst[1].tap_dr),
          128'({d2[3:0], d1[3:0], p1[DW-1:8]}));
    @(negedge clk);
    check("b2b_no_third", 128'(rsp_valid_v[1]), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
